// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller on an Avalon-MM slave (ON/OFF/enable/invert/one-shot per channel).
// Define LED_BLINK_IRQ_EN to add the irq output, CTRL.IRQ_MASK and the W1C STATUS.PEND flag.
module led_blink_ctrl #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 24,
    parameter int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic [NUM_CH-1:0] leds
`ifdef LED_BLINK_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    logic [ADDR_W-1:0] w_ch_idx;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_wr_ctrl;
    logic [NUM_CH-1:0] w_wr_on;
    logic [NUM_CH-1:0] w_wr_off;

    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_inv;
    logic [NUM_CH-1:0] r_oneshot;
    logic [CNT_W-1:0]  r_on_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_off_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_cnt     [NUM_CH];
    logic [CNT_W-1:0]  w_nxt_cnt [NUM_CH];
    state_t            r_state     [NUM_CH];
    state_t            w_nxt_state [NUM_CH];
    logic [NUM_CH-1:0] w_on_done;
    logic [NUM_CH-1:0] w_off_done;
    logic [NUM_CH-1:0] w_os_clr;
    logic [NUM_CH-1:0] w_raw;
    logic [31:0]       w_rdata;

`ifdef LED_BLINK_IRQ_EN
    logic [NUM_CH-1:0] w_wr_stat;
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] w_pend_set;
`endif

    assign w_ch_idx = avs_s0_address >> 2;
    assign w_reg    = avs_s0_address[1:0];

    // Channels at or beyond NUM_CH never match, so they read 0 and ignore writes.
    always_comb begin
        w_sel     = '0;
        w_wr_ctrl = '0;
        w_wr_on   = '0;
        w_wr_off  = '0;
`ifdef LED_BLINK_IRQ_EN
        w_wr_stat = '0;
`endif
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_sel[ch]     = (w_ch_idx == ADDR_W'(ch));
            w_wr_ctrl[ch] = avs_s0_write & w_sel[ch] & (w_reg == 2'd0);
            w_wr_on[ch]   = avs_s0_write & w_sel[ch] & (w_reg == 2'd1);
            w_wr_off[ch]  = avs_s0_write & w_sel[ch] & (w_reg == 2'd2);
`ifdef LED_BLINK_IRQ_EN
            w_wr_stat[ch] = avs_s0_write & w_sel[ch] & (w_reg == 2'd3);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en      <= '0;
            r_inv     <= '0;
            r_oneshot <= '0;
`ifdef LED_BLINK_IRQ_EN
            r_mask    <= '0;
            r_pend    <= '0;
`endif
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_on_cnt[ch]  <= '0;
                r_off_cnt[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                // A same-cycle bus write to CTRL overrides the one-shot auto-clear.
                if (w_wr_ctrl[ch]) begin
                    r_en[ch]      <= avs_s0_writedata[0];
                    r_inv[ch]     <= avs_s0_writedata[1];
                    r_oneshot[ch] <= avs_s0_writedata[2];
`ifdef LED_BLINK_IRQ_EN
                    r_mask[ch]    <= avs_s0_writedata[3];
`endif
                end else if (w_os_clr[ch]) begin
                    r_en[ch] <= 1'b0;
                end
                if (w_wr_on[ch])
                    r_on_cnt[ch] <= avs_s0_writedata[CNT_W-1:0];
                if (w_wr_off[ch])
                    r_off_cnt[ch] <= avs_s0_writedata[CNT_W-1:0];
`ifdef LED_BLINK_IRQ_EN
                if (w_pend_set[ch])
                    r_pend[ch] <= 1'b1;
                else if (w_wr_stat[ch] && avs_s0_writedata[2])
                    r_pend[ch] <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch] <= ST_IDLE;
                r_cnt[ch]   <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch] <= w_nxt_state[ch];
                r_cnt[ch]   <= w_nxt_cnt[ch];
            end
        end
    end

    // Terminal compares use >= against the live duration so a shrink ends the phase at once.
    always_comb begin
        w_on_done  = '0;
        w_off_done = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_on_done[ch]  = (r_on_cnt[ch] == '0) || (r_cnt[ch] >= r_on_cnt[ch] - CNT_W'(1));
            w_off_done[ch] = (r_off_cnt[ch] == '0) || (r_cnt[ch] >= r_off_cnt[ch] - CNT_W'(1));
        end
    end

    always_comb begin
        w_os_clr = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_nxt_state[ch] = r_state[ch];
            w_nxt_cnt[ch]   = '0;
            if (!r_en[ch]) begin
                w_nxt_state[ch] = ST_IDLE;
            end else begin
                case (r_state[ch])
                    ST_IDLE: w_nxt_state[ch] = ST_ON;
                    ST_ON: begin
                        if (w_on_done[ch])
                            w_nxt_state[ch] = ST_OFF;
                        else
                            w_nxt_cnt[ch] = r_cnt[ch] + CNT_W'(1);
                    end
                    ST_OFF: begin
                        if (w_off_done[ch]) begin
                            if (r_oneshot[ch]) begin
                                w_nxt_state[ch] = ST_IDLE;
                                w_os_clr[ch]    = 1'b1;
                            end else begin
                                w_nxt_state[ch] = ST_ON;
                            end
                        end else begin
                            w_nxt_cnt[ch] = r_cnt[ch] + CNT_W'(1);
                        end
                    end
                    default: w_nxt_state[ch] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        w_raw = '0;
`ifdef LED_BLINK_IRQ_EN
        w_pend_set = '0;
`endif
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            w_raw[ch] = r_en[ch] & (r_on_cnt[ch] != '0) &
                        ((r_off_cnt[ch] == '0) | (r_state[ch] == ST_ON));
`ifdef LED_BLINK_IRQ_EN
            w_pend_set[ch] = (r_state[ch] == ST_OFF) && (w_nxt_state[ch] != ST_OFF);
`endif
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (w_sel[ch]) begin
                case (w_reg)
                    2'd0: begin
                        w_rdata[0] = r_en[ch];
                        w_rdata[1] = r_inv[ch];
                        w_rdata[2] = r_oneshot[ch];
`ifdef LED_BLINK_IRQ_EN
                        w_rdata[3] = r_mask[ch];
`endif
                    end
                    2'd1: w_rdata[CNT_W-1:0] = r_on_cnt[ch];
                    2'd2: w_rdata[CNT_W-1:0] = r_off_cnt[ch];
                    default: begin
                        w_rdata[0] = w_raw[ch];
                        w_rdata[1] = (r_state[ch] != ST_IDLE);
`ifdef LED_BLINK_IRQ_EN
                        w_rdata[2] = r_pend[ch];
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_s0_readdata <= '0;
            leds            <= '0;
        end else begin
            if (avs_s0_read)
                avs_s0_readdata <= w_rdata;
            leds <= w_raw ^ r_inv;
        end
    end

`ifdef LED_BLINK_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |(r_pend & r_mask);
    end
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl: directed register/blink steps plus randomized blink trials checked
// against a closed-form LED model; irq steps run when LED_BLINK_IRQ_EN is defined.
module tb_led_blink_ctrl;

    localparam int NCH = 6;
    localparam int CW  = 24;
    localparam int AW  = $clog2(NCH) + 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic           rd = 1'b0;
    logic           wr = 1'b0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic [NCH-1:0] leds;
`ifdef LED_BLINK_IRQ_EN
    logic           irq;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    led_blink_ctrl #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_s0_address   (addr),
        .avs_s0_read      (rd),
        .avs_s0_write     (wr),
        .avs_s0_writedata (wdata),
        .avs_s0_readdata  (rdata),
        .leds             (leds)
`ifdef LED_BLINK_IRQ_EN
        ,
        .irq              (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        @(negedge clk);
        addr  = AW'((ch << 2) | r);
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [31:0] d);
        @(negedge clk);
        addr = AW'((ch << 2) | r);
        rd   = 1'b1;
        @(negedge clk);
        rd   = 1'b0;
        d    = rdata;
    endtask

    // Expected LED level k clock edges after the CTRL write that enabled the channel
    // (channel previously disabled with INV=0): first ON level appears at k=2.
    function automatic logic model_led(int k, int n, int m, bit inv, bit oneshot);
        int p;
        if (k < 1)  return 1'b0;
        if (n == 0) return inv;
        if (m == 0) return ~inv;
        if (k < 2)  return inv;
        p = k - 2;
        if (oneshot) return (p < n) ^ inv;
        return ((p % (n + m)) < n) ^ inv;
    endfunction

    task automatic watch(input string tag, input int ch, input int n, input int m,
                         input bit inv, input bit oneshot, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            check(tag, 32'(leds[ch]), 32'(model_led(k, n, m, inv, oneshot)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n, m, ch, zeros;
        bit          inv;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                bus_read(c, r, d);
                check("reset_reg", d, 32'd0);
            end

        // Ch0 repeating 3-on/2-off
        bus_write(0, 1, 32'd3);
        bus_write(0, 2, 32'd2);
        bus_write(0, 0, 32'd1);
        watch("ch0_blink", 0, 3, 2, 1'b0, 1'b0, 16);
        bus_read(0, 3, d);
        check("ch0_running", 32'(d[1]), 32'd1);

        // Ch2 one-shot 4-cycle pulse, EN auto-clears
        bus_write(2, 1, 32'd4);
        bus_write(2, 2, 32'd4);
        bus_write(2, 0, 32'd5);
        watch("ch2_oneshot", 2, 4, 4, 1'b0, 1'b1, 20);
        bus_read(2, 0, d);
        check("ch2_ctrl_after", d, 32'h4);
        bus_read(2, 3, d);
        check("ch2_status_after", d, 32'h0);

        // Ch1 constant levels
        bus_write(1, 1, 32'd0);
        bus_write(1, 2, 32'd5);
        bus_write(1, 0, 32'd1);
        watch("ch1_on0", 1, 0, 5, 1'b0, 1'b0, 10);
        bus_write(1, 1, 32'd3);
        bus_write(1, 2, 32'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            check("ch1_off0", 32'(leds[1]), 32'd1);
            @(negedge clk);
        end
        bus_write(1, 0, 32'd3);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("ch1_inv", 32'(leds[1]), 32'd0);
            @(negedge clk);
        end
        bus_write(1, 0, 32'd2);
        repeat (2) @(negedge clk);
        check("ch1_dis_inv", 32'(leds[1]), 32'd1);
        bus_read(1, 3, d);
        check("ch1_status_idle", d, 32'h0);

        // Asynchronous reset mid-blink, away from any clock edge
        bus_read(0, 1, d);
        check("pre_reset_rd", d, 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'd0);
        check("async_rdata", rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                bus_read(c, r, d);
                check("post_reset_reg", d, 32'd0);
            end

        // Mid-phase shrink of ON_CNT
        bus_write(0, 1, 32'd100);
        bus_write(0, 2, 32'd5);
        bus_write(0, 0, 32'd1);
        repeat (51) @(negedge clk);
        check("mid_before", 32'(leds[0]), 32'd1);
        bus_write(0, 1, 32'd10);
        check("mid_k0", 32'(leds[0]), 32'd1);
        @(negedge clk);
        check("mid_k1", 32'(leds[0]), 32'd1);
        @(negedge clk);
        check("mid_off", 32'(leds[0]), 32'd0);
        bus_read(0, 1, d);
        check("mid_on_rd", d, 32'd10);
        bus_read(NCH, 0, d);
        check("oob_rd_ctrl", d, 32'd0);
        bus_write(0, 0, 32'd0);

        // Out-of-range channel writes must not alias
        bus_write(NCH, 0, 32'd7);
        bus_write(NCH, 1, 32'd9);
        bus_write(NCH + 1, 0, 32'd1);
        bus_read(NCH + 1, 3, d);
        check("oob_rd_stat", d, 32'd0);
        for (int c = 0; c < NCH; c++) begin
            bus_read(c, 0, d);
            check("oob_no_alias", d, 32'd0);
        end
        check("oob_leds", 32'(leds), 32'd0);

        // Upper writedata bits ignored, STATUS not writable
        bus_write(4, 0, 32'hFFFF_FFF8);
        bus_read(4, 0, d);
`ifdef LED_BLINK_IRQ_EN
        check("ctrl_upper", d, 32'h8);
`else
        check("ctrl_upper", d, 32'h0);
`endif
        bus_write(4, 1, 32'hFFAB_CDEF);
        bus_read(4, 1, d);
        check("on_upper", d, 32'h00AB_CDEF);
        bus_write(4, 3, 32'hFFFF_FFFF);
        bus_read(4, 3, d);
        check("status_ro", d, 32'h0);
        bus_write(4, 0, 32'h0);
        bus_write(0, 3, 32'hFFFF_FFFF);
        bus_read(0, 3, d);
        check("status_ro_ch0", d, 32'h0);

        // Randomized blink trials
        for (int t = 0; t < 10; t++) begin
            ch  = int'($urandom_range(0, NCH - 1));
            n   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
            m   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
            inv = 1'($urandom_range(0, 1));
            bus_write(ch, 1, 32'(n));
            bus_write(ch, 2, 32'(m));
            bus_write(ch, 0, {30'd0, inv, 1'b1});
            watch("rand_blink", ch, n, m, inv, 1'b0, 2 * (n + m) + 6);
            bus_write(ch, 0, 32'h0);
            repeat (2) @(negedge clk);
            check("rand_disable", 32'(leds), 32'd0);
        end

`ifdef LED_BLINK_IRQ_EN
        bus_write(3, 1, 32'd1);
        bus_write(3, 2, 32'd1);
        bus_write(3, 0, 32'h9);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("irq_rise", 32'(irq), (k == 4) ? 32'd1 : 32'd0);
        end
        bus_read(3, 3, d);
        check("irq_pend", 32'(d[2]), 32'd1);
        bus_write(3, 3, 32'h4);
        zeros = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (irq !== 1'b1) zeros++;
        end
        check("irq_w1c_gap", 32'(zeros <= 1), 32'd1);
        check("irq_w1c_reset", 32'(irq), 32'd1);
        bus_write(3, 0, 32'h8);
        repeat (3) @(negedge clk);
        bus_write(3, 3, 32'h4);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'd0);
        bus_read(3, 3, d);
        check("irq_pend_clr", 32'(d[2]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
